sym_shift_ctrl: RTL



---
 rtl/ofdm_ctrl_pkg.sv | 22 ++
 rtl/sym_shift_ctrl.sv | 95 +++++++++
 2 files changed

// File: rtl/ofdm_ctrl_pkg.sv
// Shared definitions for the OFDM symbol-path control blocks: load-select
// encodings of the 8-bit load-select register, control state enum and
// parameter legality helper.
package ofdm_ctrl_pkg;

    localparam logic [1:0] LOAD_HOLD  = 2'd0;
    localparam logic [1:0] LOAD_DATA  = 2'd1;
    localparam logic [1:0] LOAD_SHIFT = 2'd2;
    localparam logic [1:0] LOAD_HIZ   = 2'd3;  // reserved, never issued

    typedef enum logic {
        EMPTY = 1'b0,
        SEND  = 1'b1
    } state_e;

    // Symbol width must be 1, 2 or 4 and divide the byte width evenly.
    function automatic bit sym_bits_legal(input int sym_bits, input int data_w);
        return ((sym_bits == 1) || (sym_bits == 2) || (sym_bits == 4)) &&
               ((data_w % sym_bits) == 0);
    endfunction

endpackage

// File: rtl/sym_shift_ctrl.sv
// Sequencing/flow-control stage in front of the load-select register.
// Accepts bytes over valid/ready, loads them into the register, then walks
// the byte out MSB-first as SYM_BITS-wide symbols by shifting the register
// in place. The register owns the data; this block owns only state and rem.
module sym_shift_ctrl
    import ofdm_ctrl_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int SYM_BITS = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                flush,
    input  logic [DATA_W-1:0]   reg_q,
    output logic [DATA_W-1:0]   reg_data,
    output logic [DATA_W-1:0]   reg_shift_data,
    output logic [1:0]          load_sel,
    output logic [SYM_BITS-1:0] sym_out,
    output logic                sym_valid,
    output logic                sym_last,
    input  logic                sym_ready
);

    localparam int NSYM  = DATA_W / SYM_BITS;
    localparam int REM_W = $clog2(NSYM + 1);

    generate
        if (!sym_bits_legal(SYM_BITS, DATA_W)) begin : g_bad_sym_bits
            $error("sym_shift_ctrl: illegal SYM_BITS for DATA_W");
        end
    endgenerate

    state_e             state_q, state_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic               acc, take;

    // Handshake decode and datapath steering; reset_n gates every output
    // so the register sees HOLD and the mapper sees nothing while in reset.
    always_comb begin
        sym_valid      = reset_n && (state_q == SEND);
        sym_last       = sym_valid && (rem_q == REM_W'(1));
        take           = sym_valid && sym_ready;
        in_ready       = reset_n && !flush &&
                         ((state_q == EMPTY) || (take && sym_last));
        acc            = in_valid && in_ready;
        sym_out        = reg_q[DATA_W-1 -: SYM_BITS];
        reg_data       = in_data;
        reg_shift_data = {reg_q[DATA_W-SYM_BITS-1:0], {SYM_BITS{1'b0}}};
        if (acc)
            load_sel = LOAD_DATA;
        else if (take && !sym_last && !flush)
            load_sel = LOAD_SHIFT;
        else
            load_sel = LOAD_HOLD;
    end

    // Next state: flush wins, then load of a new byte, then symbol countdown.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        if (flush) begin
            state_d = EMPTY;
            rem_d   = '0;
        end else if (state_q == EMPTY) begin
            if (acc) begin
                state_d = SEND;
                rem_d   = REM_W'(NSYM);
            end
        end else if (take) begin
            if (!sym_last) begin
                rem_d = rem_q - REM_W'(1);
            end else if (acc) begin
                rem_d = REM_W'(NSYM);   // back-to-back byte, no bubble
            end else begin
                state_d = EMPTY;
                rem_d   = '0;
            end
        end
    end

    // State and remaining-symbol counter, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

endmodule
